// File: rtl/exor_gate.sv
// exor_gate: registered bitwise XOR with parity, saturating differing-bit count and sticky diff flag
module exor_gate #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] y,
    output logic             out_valid,
    output logic             parity,
    output logic [CNT_W-1:0] mismatch_count,
    output logic             any_diff
);
    localparam int SW = CNT_W + 7;
    localparam logic [SW-1:0] CNT_MAX = SW'({CNT_W{1'b1}});

    logic [WIDTH-1:0] diff, y_d, y_q;
    logic [SW-1:0]    pop, sum;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             valid_d, valid_q, parity_d, parity_q, any_d, any_q;

    always_comb begin
        diff = a ^ b;
        pop = '0;
        for (int i = 0; i < WIDTH; i++) pop = pop + SW'(diff[i]);
        // widened sum cannot overflow, so a single compare clamps it
        sum = SW'(cnt_q) + pop;
        y_d = in_valid ? diff : y_q;
        parity_d = in_valid ? ^diff : parity_q;
        valid_d = in_valid;
        cnt_d = !in_valid ? cnt_q : (sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : sum[CNT_W-1:0];
        any_d = any_q | (in_valid & |diff);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q      <= '0;
            valid_q  <= 1'b0;
            parity_q <= 1'b0;
            cnt_q    <= '0;
            any_q    <= 1'b0;
        end else begin
            y_q      <= y_d;
            valid_q  <= valid_d;
            parity_q <= parity_d;
            cnt_q    <= cnt_d;
            any_q    <= any_d;
        end
    end

    assign y              = y_q;
    assign out_valid      = valid_q;
    assign parity         = parity_q;
    assign mismatch_count = cnt_q;
    assign any_diff       = any_q;
endmodule

// File: tb/tb_exor_gate.sv
// tb_exor_gate: drives a 1-bit gate and an 8-bit/4-bit-counter unit from one vector table
module tb_exor_gate;
    logic       clk = 1'b0, rst = 1'b1, vin = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       a1 = 1'b0, b1 = 1'b0;
    logic [7:0] y8;
    logic [3:0] c8;
    logic       ov8, p8, any8, y1, ov1, p1, any1;
    logic [15:0] c1;

    always #5 clk = ~clk;

    exor_gate #(.WIDTH(1), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(vin), .y(y1), .out_valid(ov1),
        .parity(p1), .mismatch_count(c1), .any_diff(any1));
    exor_gate #(.WIDTH(8), .CNT_W(4)) u8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .in_valid(vin), .y(y8), .out_valid(ov8),
        .parity(p8), .mismatch_count(c8), .any_diff(any8));

    typedef struct {
        logic [7:0] a, b;
        logic       v;
        logic [7:0] y8;
        logic [3:0] c8;
    } vec_t;

    typedef struct {
        logic        ov;
        logic [7:0]  y8;
        logic        p8;
        logic [3:0]  c8;
        logic        any8;
        logic        y1;
        logic [15:0] c1;
        logic        any1;
    } exp_t;

    exp_t sb[$];
    int tests = 0, fails = 0;
    logic        m_y1 = 1'b0, m_any1 = 1'b0, m_any8 = 1'b0;
    logic [15:0] m_c1 = '0;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".y8"}, y8, 0);   chk({tag, ".ov8"}, ov8, 0);  chk({tag, ".p8"}, p8, 0);
        chk({tag, ".c8"}, c8, 0);   chk({tag, ".any8"}, any8, 0);
        chk({tag, ".y1"}, y1, 0);   chk({tag, ".ov1"}, ov1, 0);  chk({tag, ".p1"}, p1, 0);
        chk({tag, ".c1"}, c1, 0);   chk({tag, ".any1"}, any1, 0);
    endtask

    // call at 1 time unit after a rising edge; asserts rst between edges
    task automatic async_reset(input string tag);
        vin = 1'b0;
        #3 rst = 1'b1;
        #1 chk_zero({tag, "_async"});
        @(posedge clk); #1;
        chk_zero({tag, "_hold"});
        rst = 1'b0;
        m_y1 = 1'b0; m_c1 = '0; m_any1 = 1'b0; m_any8 = 1'b0;
    endtask

    task automatic cycle(input string tag, input vec_t v);
        exp_t e;
        a8 = v.a; b8 = v.b; a1 = v.a[0]; b1 = v.b[0]; vin = v.v;
        if (v.v) begin
            m_y1 = v.a[0] ^ v.b[0];
            m_c1 = m_c1 + 16'(m_y1);
            m_any1 = m_any1 | m_y1;
            m_any8 = m_any8 | (|(v.a ^ v.b));
        end
        e.ov = v.v; e.y8 = v.y8; e.p8 = ^v.y8; e.c8 = v.c8; e.any8 = m_any8;
        e.y1 = m_y1; e.c1 = m_c1; e.any1 = m_any1;
        sb.push_back(e);
        @(posedge clk); #1;
        e = sb.pop_front();
        chk({tag, ".ov8"}, ov8, e.ov);    chk({tag, ".y8"}, y8, e.y8);
        chk({tag, ".p8"}, p8, e.p8);      chk({tag, ".c8"}, c8, e.c8);
        chk({tag, ".any8"}, any8, e.any8);
        chk({tag, ".ov1"}, ov1, e.ov);    chk({tag, ".y1"}, y1, e.y1);
        chk({tag, ".p1"}, p1, e.y1);      chk({tag, ".c1"}, c1, e.c1);
        chk({tag, ".any1"}, any1, e.any1);
    endtask

    vec_t tbl[14];
    vec_t hv;

    initial begin
        tbl[0]  = '{8'h00, 8'h00, 1'b1, 8'h00, 4'd0};
        tbl[1]  = '{8'h00, 8'h01, 1'b1, 8'h01, 4'd1};
        tbl[2]  = '{8'h01, 8'h00, 1'b1, 8'h01, 4'd2};
        tbl[3]  = '{8'h01, 8'h01, 1'b1, 8'h00, 4'd2};
        tbl[4]  = '{8'h01, 8'h00, 1'b1, 8'h01, 4'd3};
        tbl[5]  = '{8'hAA, 8'h55, 1'b0, 8'h01, 4'd3};
        tbl[6]  = '{8'hFF, 8'h00, 1'b0, 8'h01, 4'd3};
        tbl[7]  = '{8'h0F, 8'h3C, 1'b0, 8'h01, 4'd3};
        tbl[8]  = '{8'hF0, 8'h0F, 1'b1, 8'hFF, 4'd11};
        tbl[9]  = '{8'h01, 8'h00, 1'b1, 8'h01, 4'd12};
        tbl[10] = '{8'h3C, 8'hC3, 1'b1, 8'hFF, 4'd15};
        tbl[11] = '{8'h12, 8'h10, 1'b1, 8'h02, 4'd15};
        tbl[12] = '{8'h00, 8'h00, 1'b1, 8'h00, 4'd15};
        tbl[13] = '{8'h80, 8'h00, 1'b1, 8'h80, 4'd15};

        repeat (2) @(posedge clk);
        #1 chk_zero("reset");
        rst = 1'b0;
        for (int i = 0; i < 14; i++) cycle($sformatf("vec%0d", i), tbl[i]);

        // drop reset between edges while holding a live result
        hv = '{8'h01, 8'h00, 1'b1, 8'h01, 4'd15};
        cycle("pre_rst", hv);
        async_reset("mid");
        hv = '{8'h01, 8'h00, 1'b1, 8'h01, 4'd1};
        cycle("post_rst", hv);

        async_reset("sat");
        hv = '{8'hFF, 8'h00, 1'b1, 8'hFF, 4'd8};
        cycle("sat0", hv);
        hv = '{8'hFF, 8'h00, 1'b1, 8'hFF, 4'd15};
        cycle("sat1", hv);
        hv = '{8'h01, 8'h00, 1'b1, 8'h01, 4'd15};
        cycle("sat2", hv);
        hv = '{8'h00, 8'h00, 1'b1, 8'h00, 4'd15};
        cycle("sat3", hv);
        hv = '{8'h00, 8'h00, 1'b0, 8'h00, 4'd15};
        cycle("sat_idle", hv);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
